// File: rtl/radio_multi.sv
// rtl/radio_multi.sv - multi-channel RC PWM receiver on a 1 MHz timebase
// Optional macro RADIO_FAILSAFE_EN: reload DEFAULT into a channel's value when it goes lost.
module radio_multi #(
  parameter int CHANNELS   = 6,
  parameter int WIDTH      = 10,
  parameter int DEFAULT    = 512,
  parameter int MIN_US     = 987,
  parameter int MIN_PULSE  = 500,
  parameter int MAX_PULSE  = 2500,
  parameter int TIMEOUT_US = 25000
) (
  input  logic                      tmr_1Mhz,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       sig,
  output logic [CHANNELS*WIDTH-1:0] val,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       lost
);

  localparam logic [15:0]      TMO      = 16'(TIMEOUT_US);
  localparam logic [15:0]      MINP     = 16'(MIN_PULSE);
  localparam logic [15:0]      MAXP     = 16'(MAX_PULSE);
  localparam logic [16:0]      MINU     = 17'(MIN_US);
  localparam logic [15:0]      SPAN     = 16'((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0] DEF      = WIDTH'(DEFAULT);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [CHANNELS-1:0] s1, s2, sp;
  logic [CHANNELS-1:0] armed;
  logic [CHANNELS-1:0] rise, fall;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] lost_nxt;
  logic [15:0]         ctr      [CHANNELS];
  logic [15:0]         tcnt     [CHANNELS];
  logic [15:0]         tcnt_nxt [CHANNELS];
  logic [16:0]         diff     [CHANNELS];
  logic [WIDTH-1:0]    mapped   [CHANNELS];

  assign rise = s2 & ~sp;
  assign fall = ~s2 & sp;

  always_comb begin
    accept   = '0;
    lost_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tcnt_nxt[i] = tcnt[i];
      diff[i]     = {1'b0, ctr[i]} - MINU;
      mapped[i]   = '0;
      accept[i]   = fall[i] && (ctr[i] >= MINP) && (ctr[i] <= MAXP);
      // diff[16] is the borrow: width below MIN_US clamps to zero
      if (diff[i][16])
        mapped[i] = '0;
      else if (diff[i][15:0] > SPAN)
        mapped[i] = ALL_ONES;
      else
        mapped[i] = diff[i][WIDTH-1:0];
      if (accept[i])
        tcnt_nxt[i] = '0;
      else if (tcnt[i] < TMO)
        tcnt_nxt[i] = tcnt[i] + 16'd1;
      lost_nxt[i] = !accept[i] && (tcnt_nxt[i] == TMO);
    end
  end

  always_ff @(posedge tmr_1Mhz) begin
    if (rst) begin
      s1    <= '1;
      s2    <= '1;
      sp    <= '1;
      armed <= '0;
      valid <= '0;
      lost  <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        ctr[i]                <= '0;
        tcnt[i]               <= TMO;
        val[i*WIDTH +: WIDTH] <= DEF;
      end
    end else begin
      s1 <= sig;
      s2 <= s1;
      sp <= s2;
      for (int i = 0; i < CHANNELS; i++) begin
        // Counting waits for a real rising edge, so a pulse cut by reset measures zero
        if (rise[i]) begin
          armed[i] <= 1'b1;
          ctr[i]   <= 16'd1;
        end else if (s2[i] && armed[i] && (ctr[i] != 16'hFFFF)) begin
          ctr[i] <= ctr[i] + 16'd1;
        end
        valid[i] <= accept[i];
        tcnt[i]  <= tcnt_nxt[i];
        lost[i]  <= lost_nxt[i];
        if (accept[i])
          val[i*WIDTH +: WIDTH] <= mapped[i];
`ifdef RADIO_FAILSAFE_EN
        else if (lost_nxt[i] && !lost[i])
          val[i*WIDTH +: WIDTH] <= DEF;
`else
`endif
      end
    end
  end

endmodule

// File: tb/tb_radio_multi.sv
// tb/tb_radio_multi.sv - directed self-checking bench for radio_multi
module tb_radio_multi;

  localparam int CH = 6;
  localparam int W  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   sig;
  logic [CH*W-1:0] val;
  logic [CH-1:0]   valid;
  logic [CH-1:0]   lost;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_last = 0;
  int scount [CH];

  always #5 clk = ~clk;

  radio_multi dut (
    .tmr_1Mhz (clk),
    .rst      (rst),
    .sig      (sig),
    .val      (val),
    .valid    (valid),
    .lost     (lost)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst === 1'b0)
      for (int i = 0; i < CH; i++)
        if (valid[i] === 1'b1) scount[i] = scount[i] + 1;

  function automatic logic [W-1:0] vch(input int i);
    return val[i*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int ch, input int n,
                       output logic [CH-1:0] pre, output logic [CH-1:0] at,
                       output logic [CH-1:0] post);
    @(posedge clk); #1 sig[ch] = 1'b1;
    repeat (n) @(posedge clk);
    #1 sig[ch] = 1'b0;
    repeat (2) @(posedge clk);
    #1 pre = valid;
    @(posedge clk);
    #1 at = valid;
    t_last = cyc;
    @(posedge clk);
    #1 post = valid;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] pre, at, post;
    int w1 [4];
    int e1 [4];
    int t2, t3, c, sum;
    logic [31:0] fs_exp;

    for (int i = 0; i < CH; i++) scount[i] = 0;
    w1 = '{987, 900, 2010, 2100};
    e1 = '{0, 0, 1023, 1023};

    rst = 1'b1;
    sig = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < CH; i++) chk($sformatf("reset_val%0d", i), 32'(vch(i)), 32'd512);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_lost", 32'(lost), 32'h3F);
    repeat (10) @(posedge clk);
    #1;
    sum = 0;
    for (int i = 0; i < CH; i++) sum += scount[i];
    chk("reset_no_strobe", 32'(sum), 32'd0);

    pulse(0, 1500, pre, at, post);
    chk("ch0_pre", 32'(pre), 32'd0);
    chk("ch0_at", 32'(at), 32'h01);
    chk("ch0_post", 32'(post), 32'd0);
    chk("ch0_val", 32'(vch(0)), 32'd513);
    chk("ch0_lost", 32'(lost), 32'h3E);
    for (int i = 1; i < CH; i++) chk($sformatf("ch0_other_val%0d", i), 32'(vch(i)), 32'd512);

    for (int k = 0; k < 4; k++) begin
      pulse(1, w1[k], pre, at, post);
      chk($sformatf("ch1_pre_%0d", w1[k]), 32'(pre), 32'd0);
      chk($sformatf("ch1_at_%0d", w1[k]), 32'(at), 32'h02);
      chk($sformatf("ch1_post_%0d", w1[k]), 32'(post), 32'd0);
      chk($sformatf("ch1_val_%0d", w1[k]), 32'(vch(1)), 32'(e1[k]));
    end
    chk("ch1_strobes", 32'(scount[1]), 32'd4);

    pulse(2, 1500, pre, at, post);
    chk("ch2_accept_at", 32'(at), 32'h04);
    chk("ch2_accept_val", 32'(vch(2)), 32'd513);
    t2 = t_last;
    c = scount[2];
    pulse(2, 100, pre, at, post);
    chk("ch2_glitch_at", 32'(at), 32'd0);
    pulse(2, 3000, pre, at, post);
    chk("ch2_long_at", 32'(at), 32'd0);
    chk("ch2_reject_strobes", 32'(scount[2]), 32'(c));
    chk("ch2_reject_val", 32'(vch(2)), 32'd513);

    pulse(3, 1200, pre, at, post);
    chk("ch3_at", 32'(at), 32'h08);
    chk("ch3_val", 32'(vch(3)), 32'd213);
    t3 = t_last;

    while (cyc < t2 + 24999) begin @(posedge clk); #1; end
    chk("ch2_lost_before", 32'(lost[2]), 32'd0);
    @(posedge clk); #1;
    chk("ch2_lost_edge", 32'(lost[2]), 32'd1);

    while (cyc < t3 + 24999) begin @(posedge clk); #1; end
    chk("ch3_lost_before", 32'(lost[3]), 32'd0);
    chk("ch3_val_before", 32'(vch(3)), 32'd213);
    @(posedge clk); #1;
    chk("ch3_lost_edge", 32'(lost[3]), 32'd1);
`ifdef RADIO_FAILSAFE_EN
    fs_exp = 32'd512;
`else
    fs_exp = 32'd213;
`endif
    chk("ch3_val_lost", 32'(vch(3)), fs_exp);
    chk("ch3_no_fs_strobe", 32'(valid), 32'd0);

    @(posedge clk); #1 sig[5] = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      repeat (100) @(posedge clk);
      #1 sig[i] = 1'b1;
    end
    repeat (1000) @(posedge clk);
    #1 sig = '0;
    repeat (2) @(posedge clk);
    #1 chk("all_pre", 32'(valid), 32'd0);
    @(posedge clk);
    #1 chk("all_at", 32'(valid), 32'h3F);
    for (int i = 0; i < CH; i++) chk($sformatf("all_val%0d", i), 32'(vch(i)), 32'(13 + 100 * i));
    chk("all_lost", 32'(lost), 32'd0);
    @(posedge clk);
    #1 chk("all_post", 32'(valid), 32'd0);

    @(posedge clk); #1 sig[0] = 1'b1;
    repeat (1000) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    c = scount[0];
    repeat (1000) @(posedge clk);
    #1 sig[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_strobes", 32'(scount[0]), 32'(c));
    chk("midrst_val", 32'(vch(0)), 32'd512);
    chk("midrst_lost", 32'(lost), 32'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/radio_multi.md
Name: radio_multi

Overview:
Parametrised multi-channel RC receiver front end. It measures the high time of up to CHANNELS independent PWM inputs on a single 1 MHz timebase, so one count equals 1 us. Each width is mapped to a WIDTH-bit value offset from MIN_US, with glitch and over-length rejection, per-channel valid strobes and loss-of-signal detection. It sits between the receiver pins and the flight-control input stage, and supersedes the single-channel, edge-clocked reader with a fully synchronous design.

Parameters:
CHANNELS, 6, number of independent PWM inputs (1..16)
WIDTH, 10, output value width per channel; span = 2^WIDTH counts
DEFAULT, 512, value loaded on reset and on failsafe; must fit in WIDTH bits
MIN_US, 987, pulse width mapped to value 0
MIN_PULSE, 500, shortest accepted pulse in us; shorter pulses are glitches
MAX_PULSE, 2500, longest accepted pulse in us; longer pulses are rejected
TIMEOUT_US, 25000, us without an accepted pulse before the channel is declared lost; must be <= 65535

Ports:
tmr_1Mhz  in   1               1 MHz clock, sole clock of the block
rst       in   1               synchronous reset, active-high
sig       in   CHANNELS        raw PWM inputs, asynchronous to tmr_1Mhz
val       out  CHANNELS*WIDTH  registered values; channel i occupies [i*WIDTH +: WIDTH]
valid     out  CHANNELS        one-cycle strobe: val[i] updated this cycle
lost      out  CHANNELS        level: channel i has timed out or has had no accepted pulse since reset

Behaviour:
- Everything is clocked on posedge tmr_1Mhz. Reset is synchronous and active-high. No logic is clocked by sig.
- Synchroniser: two flops per channel (s1, s2) feed a history flop (sp). All three reset to 1.
  - rise = s2 & ~sp; fall = ~s2 & sp.
  - Because the flops reset to 1, an input held high through reset release produces no rise. Its first fall is then rejected as a zero-length pulse.
- Width counter ctr[i], 16 bits:
  - reset to 0;
  - on rise: ctr <= 1;
  - while s2 = 1 and no rise: ctr <= ctr + 1, saturating at 0xFFFF;
  - otherwise hold.
  - A pin high for exactly N clocks gives ctr = N on the fall cycle.
- Acceptance, evaluated on the fall cycle: accept iff MIN_PULSE <= ctr <= MAX_PULSE.
- Mapping, on accept:
  - ctr < MIN_US: val = 0;
  - ctr - MIN_US > 2^WIDTH - 1: val = all ones;
  - else val = ctr - MIN_US, truncated to WIDTH bits.
  - The subtraction is done at 16+1 bits; no wrap is permitted.
- On accept, at the same edge: val[i] updates, valid[i] = 1 for exactly one cycle, tcnt[i] <= 0, lost[i] <= 0.
- On reject: no change to val, valid, lost or tcnt. A rejected pulse does not refresh the timeout.
- Latency: val and valid update on the 3rd rising edge after the pin falls (2 sync stages + edge detect).
- Timeout counter tcnt[i], 16 bits:
  - reset to TIMEOUT_US;
  - increments every cycle, saturating at TIMEOUT_US.
  - lost[i] = 1 on the edge where tcnt becomes TIMEOUT_US, i.e. TIMEOUT_US cycles after the last valid strobe.
- Stuck-high input: ctr saturates, tcnt keeps running and lost asserts. The eventual fall is rejected (> MAX_PULSE).
- Simultaneous events:
  - Channels are fully independent; any subset may strobe in the same cycle.
  - If an accept and a timeout coincide on one channel, the accept wins: lost = 0 and tcnt = 0.
- Reset values: val = DEFAULT on every channel, valid = 0, lost = all ones, ctr = 0, tcnt = TIMEOUT_US.
- Reset mid-pulse aborts the measurement. No valid strobe follows reset release for that pulse.

Optional Feature:
RADIO_FAILSAFE_EN
- Defined: on the edge where lost[i] rises, val[i] <= DEFAULT. No valid strobe is issued for this load.
- Undefined: val[i] holds its last accepted value while lost[i] is asserted.
- lost behaviour is identical either way.

Test Plan:
- Assert rst for 4 cycles, then release with all sig low -> val = 512 on every channel, valid = 0, lost = all ones. No strobes follow, including the spurious fall on the first cycle.
- Ch0 pin high 1500 cycles, others idle -> 3 edges after the fall: val0 = 513, valid[0] high for 1 cycle, lost[0] = 0; other channels unchanged.
- Ch1 pulses of 987, 900, 2010 and 2100 cycles -> val1 = 0, 0, 1023, 1023 respectively, each with a single valid strobe.
- Ch2 pulses of 100 and 3000 cycles after an accepted 1500 -> no valid, val2 stays 513, tcnt is not cleared.
- Ch3 accepts 1200 (val = 213), then stays idle -> lost[3] rises exactly 25000 cycles after the strobe. With RADIO_FAILSAFE_EN val3 = 512 at that edge; without it val3 = 213.
- All 6 channels with widths 1000, 1100, ..., 1500 falling in the same cycle -> all valid bits high together; val = 13, 113, 213, 313, 413, 513. Assert rst mid-pulse on ch0 -> no strobe follows.
